// File: rtl/fir_decimator_pkg.sv
// Shared definitions for the FIR decimator: control state encoding,
// default widths and the occupancy-counter width helper.
package fir_decimator_pkg;

    // WARM discards the FIR fill transient; RUN decimates until reset.
    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } dec_state_t;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_WARMUP     = 19;  // FIR tap count
    localparam int DEF_DECIM      = 4;
    localparam int DEF_FIFO_DEPTH = 8;

    // Width of an occupancy counter that must reach depth itself.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered head,
// occupancy and full/empty flags. A push while full is accepted only
// when a pop happens on the same edge (the freed slot is reused).
module fir_sync_fifo
    import fir_decimator_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic                              pop,
    input  logic [DATA_W-1:0]                 din,
    output logic [DATA_W-1:0]                 dout,
    output logic                              full,
    output logic                              empty,
    output logic [count_w(FIFO_DEPTH)-1:0]    count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = count_w(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_next;
    logic              do_push;
    logic              do_pop;
    logic [CW-1:0]     count_next;

    // Qualify requests against the current occupancy and compute next count.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        rd_next    = rd_ptr + AW'(1);
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers, flags and the registered fall-through head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_next;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(FIFO_DEPTH));
            if (do_pop) begin
                // Next entry already stored, or the incoming word becomes head.
                if (count > CW'(1)) dout <= mem[rd_next];
                else if (do_push)   dout <= din;
            end else if (do_push && empty) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// Decimator placed after the 19-tap FIR: drops the first WARMUP accepted
// samples, then keeps one sample per DECIM accepted samples and buffers
// them in an FWFT FIFO.
// Build option FIR_DECIM_AVG_EN: instead of picking the phase-0 sample,
// push the floor average of each DECIM-sample group on its last phase.
//
// Output handshake: out_valid is high whenever the FIFO holds data and
// out_data is then the oldest entry; a word is consumed on every rising
// edge where out_valid && out_ready. out_ready is a don't-care while
// out_valid is low, and out_valid never depends combinationally on it.
module fir_decimator
    import fir_decimator_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DECIM      = DEF_DECIM,
    parameter int WARMUP     = DEF_WARMUP,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_en,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [count_w(FIFO_DEPTH)-1:0] fifo_count,
    output logic                           overflow
);

    localparam int PH_W = $clog2(DECIM);
    localparam int WC_W = $clog2(WARMUP + 1);

    dec_state_t        state;
    logic [WC_W-1:0]   warm_cnt;
    logic [PH_W-1:0]   phase;
    logic              push_req;
    logic [DATA_W-1:0] push_val;
    logic              fifo_push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

`ifdef FIR_DECIM_AVG_EN
    localparam int ACC_W = DATA_W + PH_W;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] sum;

    // Group sum including the current sample; the top DATA_W bits are the
    // arithmetic shift by log2(DECIM), i.e. the floor average.
    always_comb begin
        in_ext   = {{PH_W{in_data[DATA_W-1]}}, in_data};
        sum      = acc + in_ext;
        push_req = (state == RUN) && in_en && (phase == PH_W'(DECIM - 1));
        push_val = sum[ACC_W-1:PH_W];
    end

    // Accumulator reloads with the first sample of each group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (state == RUN && in_en) begin
            acc <= (phase == '0) ? in_ext : sum;
        end
    end
`else
    // Pick mode: the phase-0 sample passes through untouched.
    always_comb begin
        push_req = (state == RUN) && in_en && (phase == '0);
        push_val = in_data;
    end
`endif

    // Handshake glue: pop on valid&&ready, push only when a slot exists.
    always_comb begin
        pop       = out_valid && out_ready;
        fifo_push = push_req && (!fifo_full || pop);
    end

    // Warm-up/phase control and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WARM;
            warm_cnt <= '0;
            phase    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_req && fifo_full && !pop) overflow <= 1'b1;
            if (in_en) begin
                if (state == WARM) begin
                    warm_cnt <= warm_cnt + WC_W'(1);
                    if (warm_cnt == WC_W'(WARMUP - 1)) state <= RUN;
                end else begin
                    phase <= phase + PH_W'(1);
                end
            end
        end
    end

    fir_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (pop),
        .din   (push_val),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator: random stimulus against a
// sample-index based reference model with a queue standing in for the FIFO.
module tb_fir_decimator;

    localparam int W      = 16;
    localparam int DECIM  = 4;
    localparam int WARMUP = 19;
    localparam int DEPTH  = 8;
`ifdef FIR_DECIM_AVG_EN
    localparam int KEEP_PH = DECIM - 1;
`else
    localparam int KEEP_PH = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_en = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [3:0]   fifo_count;
    logic         overflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    int           acc_cnt;
    int           grp_sum;
    logic         m_ovf;
    logic [W-1:0] m_last;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    fir_decimator dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_en      (in_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // ---------------- reference model ----------------
    function automatic void model_reset();
        exp_q.delete();
        acc_cnt = 0;
        grp_sum = 0;
        m_ovf   = 1'b0;
        m_last  = '0;
    endfunction

    // Next accepted sample produces a push?
    function automatic bit next_kept();
        return (acc_cnt >= WARMUP) && (((acc_cnt - WARMUP) % DECIM) == KEEP_PH);
    endfunction

    function automatic void model_edge(input logic en, input logic [W-1:0] d, input logic rdy);
        bit           have = 0;
        logic [W-1:0] val = '0;
        int           s, r, q;
        bit           popped;
        popped = rdy && (exp_q.size() != 0);
        if (en) begin
            if (acc_cnt >= WARMUP) begin
                s = int'($signed(d));
                r = (acc_cnt - WARMUP) % DECIM;
`ifdef FIR_DECIM_AVG_EN
                if (r == 0) grp_sum = s;
                else        grp_sum = grp_sum + s;
                if (r == DECIM - 1) begin
                    q = grp_sum / DECIM;
                    if ((grp_sum % DECIM) != 0 && grp_sum < 0) q = q - 1;
                    val  = q[W-1:0];
                    have = 1;
                end
`else
                if (r == 0) begin
                    val  = d;
                    have = 1;
                end
`endif
            end
            acc_cnt++;
        end
        if (popped) void'(exp_q.pop_front());
        if (have) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(val);
            else                      m_ovf = 1'b1;
        end
        if (exp_q.size() != 0) m_last = exp_q[0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic en, input logic [W-1:0] d, input logic rdy);
        in_en     = en;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        model_edge(en, d, rdy);
        #1;
    endtask

    task automatic do_reset();
        in_en     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic warm_up();
        for (int i = 0; i < WARMUP; i++) step(1'b1, W'($urandom_range(0, 65535)), 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset out_data: got %h want 0", out_data); end
        n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL reset fifo_count: got %0d want 0", fifo_count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b want 0", overflow); end
        reset = 1'b0;
    endtask

    task automatic test_warmup();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(1'b1, W'(i), (i >= 24) ? 1'(($urandom_range(0, 3) != 0)) : 1'b0);
            if (i < WARMUP) begin
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL warmup early_valid @%0d: got %b want 0", i, out_valid); end
            end
            n_vec++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL warmup out_valid @%0d: got %b want %b", i, out_valid, exp_q.size() != 0); end
            n_vec++; if (out_data !== m_last) begin n_err++; $display("FAIL warmup out_data @%0d: got %h want %h", i, out_data, m_last); end
            n_vec++; if (fifo_count !== 4'(exp_q.size())) begin n_err++; $display("FAIL warmup fifo_count @%0d: got %0d want %0d", i, fifo_count, exp_q.size()); end
        end
    endtask

    task automatic test_gaps();
        logic en;
        do_reset();
        warm_up();
        for (int i = 0; i < 80; i++) begin
            en = 1'(i % 2 == 0);
            step(en, W'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            n_vec++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL gaps out_valid @%0d: got %b want %b", i, out_valid, exp_q.size() != 0); end
            n_vec++; if (out_data !== m_last) begin n_err++; $display("FAIL gaps out_data @%0d: got %h want %h", i, out_data, m_last); end
            n_vec++; if (fifo_count !== 4'(exp_q.size())) begin n_err++; $display("FAIL gaps fifo_count @%0d: got %0d want %0d", i, fifo_count, exp_q.size()); end
            n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL gaps overflow @%0d: got %b want %b", i, overflow, m_ovf); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        warm_up();
        for (int i = 0; i < DECIM * 9; i++) begin
            step(1'b1, W'($urandom_range(0, 65535)), 1'b0);
            n_vec++; if (fifo_count !== 4'(exp_q.size())) begin n_err++; $display("FAIL ovf fill_count @%0d: got %0d want %0d", i, fifo_count, exp_q.size()); end
            n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL ovf flag @%0d: got %b want %b", i, overflow, m_ovf); end
        end
        n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ovf full_count: got %0d want 8", fifo_count); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf sticky_set: got %b want 1", overflow); end
        for (int i = 0; i < DEPTH + 2; i++) begin
            n_vec++; if (out_valid && out_data !== m_last) begin n_err++; $display("FAIL ovf drain_data @%0d: got %h want %h", i, out_data, m_last); end
            step(1'b0, W'($urandom_range(0, 65535)), 1'b1);
            n_vec++; if (fifo_count !== 4'(exp_q.size())) begin n_err++; $display("FAIL ovf drain_count @%0d: got %0d want %0d", i, fifo_count, exp_q.size()); end
            n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf sticky_hold @%0d: got %b want 1", i, overflow); end
        end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf drained_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_full_pop();
        do_reset();
        warm_up();
        for (int i = 0; i < 200 && exp_q.size() < DEPTH; i++) step(1'b1, W'($urandom_range(0, 65535)), 1'b0);
        for (int i = 0; i < DECIM + 1 && !next_kept(); i++) step(1'b1, W'($urandom_range(0, 65535)), 1'b0);
        n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL fullpop pre_count: got %0d want 8", fifo_count); end
        step(1'b1, W'($urandom_range(0, 65535)), 1'b1);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop overflow: got %b want 0", overflow); end
        n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL fullpop count: got %0d want 8", fifo_count); end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++; if (out_data !== m_last) begin n_err++; $display("FAIL fullpop order @%0d: got %h want %h", i, out_data, m_last); end
            step(1'b0, '0, 1'b1);
        end
        n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL fullpop drained: got %0d want 0", fifo_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        warm_up();
        for (int i = 0; i < 200 && exp_q.size() < 5; i++) step(1'b1, W'($urandom_range(0, 65535)), 1'b0);
        step(1'b1, W'($urandom_range(0, 65535)), 1'b1); // one extra edge mid-stream
        for (int i = 0; i < 200 && exp_q.size() != 5; i++) step(1'b1, W'($urandom_range(0, 65535)), 1'b0);
        m_ovf = 1'b1; // force overflow to set so the reset is seen to clear it
        for (int i = 0; i < DECIM * 4; i++) step(1'b1, W'($urandom_range(0, 65535)), 1'b0);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL areset pre_overflow: got %b want 1", overflow); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset out_valid: got %b want 0", out_valid); end
        n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL areset fifo_count: got %0d want 0", fifo_count); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL areset overflow: got %b want 0", overflow); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL areset out_data: got %h want 0", out_data); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < WARMUP + DECIM * 2; i++) begin
            step(1'b1, W'($urandom_range(0, 65535)), 1'b0);
            n_vec++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL areset rewarm_valid @%0d: got %b want %b", i, out_valid, exp_q.size() != 0); end
            n_vec++; if (out_data !== m_last) begin n_err++; $display("FAIL areset rewarm_data @%0d: got %h want %h", i, out_data, m_last); end
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] grp[12];
        logic [W-1:0] want[3];
        int           k;
        grp = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC,
                16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                16'h8000, 16'h8000, 16'h8000, 16'h8000};
`ifdef FIR_DECIM_AVG_EN
        want = '{16'hFFFD, 16'h7FFF, 16'h8000};
`else
        want = '{16'hFFFF, 16'h7FFF, 16'h8000};
`endif
        do_reset();
        warm_up();
        k = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, grp[i], 1'b1);
            n_vec++; if (out_data !== m_last) begin n_err++; $display("FAIL extreme model_data @%0d: got %h want %h", i, out_data, m_last); end
            if ((i % DECIM) == KEEP_PH) begin
                n_vec++; if (out_valid !== 1'b1 || out_data !== want[k]) begin n_err++; $display("FAIL extreme group%0d: got %b/%h want 1/%h", k, out_valid, out_data, want[k]); end
                k++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        warm_up();
        for (int i = 0; i < 150; i++) begin
            step(1'($urandom_range(0, 7) != 0), W'($urandom_range(0, 65535)), 1'($urandom_range(0, 3) == 0));
            n_vec++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL b2b out_valid @%0d: got %b want %b", i, out_valid, exp_q.size() != 0); end
            n_vec++; if (out_data !== m_last) begin n_err++; $display("FAIL b2b out_data @%0d: got %h want %h", i, out_data, m_last); end
            n_vec++; if (fifo_count !== 4'(exp_q.size())) begin n_err++; $display("FAIL b2b fifo_count @%0d: got %0d want %0d", i, fifo_count, exp_q.size()); end
            n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL b2b overflow @%0d: got %b want %b", i, overflow, m_ovf); end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        model_reset();
        test_reset();
        test_warmup();
        test_gaps();
        test_overflow();
        test_full_pop();
        test_async_reset();
        test_extremes();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream neighbour of the 19-tap pipelined FIR.
- Consumes one signed 16-bit filtered sample per clock while `in_en` is high.
- Discards the FIR pipeline fill transient, then keeps every DECIM-th sample and buffers the kept samples in a small first-word-fall-through FIFO.
- Presents the buffered samples on a valid/ready output for the next consumer (DAC, serializer or host capture).

Parameters:
- DATA_W, 16, sample width; matches the FIR `data_out`.
- DECIM, 4, decimation ratio; must be ≥ 2 and a power of 2.
- WARMUP, 19, number of accepted input samples discarded after reset; equals the FIR tap count.
- FIFO_DEPTH, 8, FIFO entries; must be a power of 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  signed sample from the FIR `data_out`.
- in_en  input  1  input sample valid this cycle; tie high for a continuous FIR.
- out_data  output  DATA_W  signed decimated sample at the FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts; a pop occurs when out_valid && out_ready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; a kept sample was dropped because the FIFO was full.

Behaviour:
- **Reset.** Asserting reset acts immediately, mid-operation included.
  - State goes to WARM, warm counter = 0, phase = 0, accumulator = 0.
  - FIFO pointers = 0; out_valid = 0, out_data = 0, fifo_count = 0, overflow = 0.
  - FIFO contents are discarded.
- **Input gating.** Cycles with in_en = 0 are ignored entirely: no counter advances, no push.
- **State WARM.** Each accepted sample increments the warm counter. The sample that brings the count to WARMUP is discarded, and the block moves to RUN on that edge. No pushes occur in WARM.
- **State RUN.**
  - phase counts 0..DECIM-1 on accepted samples and wraps to 0.
  - The sample accepted at phase 0 is "kept". It is the first sample after warm-up, and then every DECIM-th sample.
  - RUN is left only by reset.
- **Push.**
  - A kept sample is written on the same edge it is accepted.
  - If the FIFO is full and no pop occurs that cycle: the sample is dropped, overflow sets, and FIFO contents are unchanged.
  - If the FIFO is full and a pop occurs the same cycle: the push succeeds and the count stays at FIFO_DEPTH.
- **Pop.** Occurs on a clock edge where out_valid && out_ready. Simultaneous push and pop with the FIFO non-full leaves the count unchanged.
- **Empty FIFO.** out_ready is ignored; out_data holds its last value.
- **Output timing.** First-word fall-through, all outputs registered.
  - A push into an empty FIFO at edge t drives out_valid = 1 and out_data = that sample from edge t onward.
  - Overall latency is 0 cycles of added delay from the kept input edge to out_valid.
- **Pointers.** Write and read pointers wrap modulo FIFO_DEPTH. Full is count == FIFO_DEPTH; empty is count == 0.
- **overflow.** Cleared only by reset.
- **Arithmetic.** Pick mode performs no arithmetic; the sample passes bit-exact, sign preserved.

Optional Feature:
- Macro: FIR_DECIM_AVG_EN.
- **Defined (boxcar-average mode).**
  - In RUN, the block accumulates DECIM consecutive accepted samples (phase 0..DECIM-1) in a signed accumulator of DATA_W+$clog2(DECIM) bits.
  - At phase DECIM-1 it pushes the sum arithmetically shifted right by $clog2(DECIM): truncation toward −∞, no rounding, always fits DATA_W.
  - The accumulator reloads with the phase-0 sample of the next group.
  - The push happens on the phase DECIM-1 edge.
- **Undefined.** Pick mode as in Behaviour; no accumulator is synthesised.

Decomposition:
- Shared package: WARM/RUN state enum, default DATA_W = 16, WARMUP = 19 (FIR tap count), and the count-width function used by fifo_count.
- One sub-module: fir_sync_fifo (FWFT, parameters DATA_W and FIFO_DEPTH; ports push, pop, din, dout, full, empty, count).
- fir_decimator holds the warm-up/phase control and the optional accumulator.

Test Plan:
- **Reset/warm-up.** reset pulse, in_en = 1, in_data = 0, 1, 2, … per cycle → first push is sample 19; with DECIM = 4 the kept values are 19, 23, 27, …; no out_valid before the 20th accepted sample.
- **Input gaps.** in_en toggles 1,0,1,0 after warm-up → kept samples still every 4th *accepted* sample; gap cycles change nothing.
- **Overflow.** out_ready = 0 with continuous input → fifo_count reaches 8 after 8 kept samples; the 9th is dropped and overflow = 1 and stays set. out_ready = 1 then drains 8 values in order, with the first-stored value at the head.
- **Full with simultaneous pop.** FIFO full, out_ready = 1 on the cycle a kept sample arrives → no overflow, count stays 8, order intact.
- **Async reset mid-stream.** Assert reset between clock edges with count = 5 → out_valid, fifo_count and overflow are 0 immediately; after release the WARMUP discard restarts.
- **AVG (FIR_DECIM_AVG_EN).** After warm-up, groups {−1, −2, −3, −4} → −3 (−10 >>> 2), {32767 ×4} → 32767, {−32768 ×4} → −32768.
